// File: rtl/regfile_read_2p.sv
// ---------------------------------------------------------------------------
// regfile_read_2p
//   Register file for the MIPS datapath: 2**ADDR_WIDTH words of DATA_WIDTH
//   bits, one write port and two registered read ports. It feeds the ALU
//   operand registers in the decode stage.
//
//   Register 0 is hardwired to zero. It is forced to zero on read, and no
//   write ever targets it.
//
//   A write and a read of the same register on the same edge return the new
//   data (write-first bypass). This lets decode read a value that writeback
//   commits on that same edge, so the two stages never collide.
//
// Ports
//   CLK     in   1           clock, rising edge
//   RST     in   1           synchronous reset, active-high; clears every
//                            register and the read outputs, and overrides
//                            WE/RE on the same edge
//   WE      in   1           write enable
//   WA      in   ADDR_WIDTH  write address (WA==0 is ignored)
//   WD      in   DATA_WIDTH  write data
//   RE      in   1           read request
//   RA1     in   ADDR_WIDTH  read address, port 1
//   RA2     in   ADDR_WIDTH  read address, port 2
//   RD1     out  DATA_WIDTH  registered read data, port 1
//   RD2     out  DATA_WIDTH  registered read data, port 2
//   RVALID  out  1           newly captured read data on RD1/RD2
//
// Read handshake: RE is a request with no ready or backpressure. Each edge
// that samples RE=1 (with RST=0) loads RD1/RD2 and raises RVALID for exactly
// the following cycle. RVALID stays high across cycles only while RE stays
// high on consecutive edges. RD1/RD2 keep the last captured data until the
// next accepted RE or RST. A consumer that misses the RVALID cycle must
// issue RE again.
// ---------------------------------------------------------------------------
module regfile_read_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WA,
  input  logic [DATA_WIDTH-1:0] WD,
  input  logic                  RE,
  input  logic [ADDR_WIDTH-1:0] RA1,
  input  logic [ADDR_WIDTH-1:0] RA2,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic                  RVALID
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // Flat storage. Entry 0 exists, but it is never written after reset and
  // it is masked on read.
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  write_en;
  logic [DATA_WIDTH-1:0] rd1_next;
  logic [DATA_WIDTH-1:0] rd2_next;

  // A write is committed only to a non-zero address.
  assign write_en = WE && (WA != '0);

  // Read mux with write-first bypass. The two ports are decoded
  // independently. Address 0 always yields zero, whatever the write port
  // is doing.
  always_comb begin
    rd1_next = '0;
    rd2_next = '0;
    if (RA1 != '0) begin
      if (write_en && (WA == RA1)) rd1_next = WD;
      else                         rd1_next = regs[RA1];
    end
    if (RA2 != '0) begin
      if (write_en && (WA == RA2)) rd2_next = WD;
      else                         rd2_next = regs[RA2];
    end
  end

  // Storage update
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[WA] <= WD;
    end
  end

  // Registered read ports. RVALID is a one-cycle pulse for each accepted RE.
  // The data registers hold their value when RE is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RD1    <= '0;
      RD2    <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= RE;
      if (RE) begin
        RD1 <= rd1_next;
        RD2 <= rd2_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_2p.sv
// ---------------------------------------------------------------------------
// tb_regfile_read_2p
//   Self-checking bench for regfile_read_2p. The bench holds its own copy of
//   the register contents. Each read request pushes the expected RD1/RD2
//   pair to a queue. The pair is popped and compared when RVALID shows the
//   data. On every edge the bench also checks RVALID and the held RD
//   values.
// ---------------------------------------------------------------------------
module tb_regfile_read_2p;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2 ** AW;

  // clock / reset block
  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          WE  = 1'b0;
  logic [AW-1:0] WA  = '0;
  logic [DW-1:0] WD  = '0;
  logic          RE  = 1'b0;
  logic [AW-1:0] RA1 = '0;
  logic [AW-1:0] RA2 = '0;
  logic [DW-1:0] RD1;
  logic [DW-1:0] RD2;
  logic          RVALID;

  always #5 CLK = ~CLK;

  regfile_read_2p #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .WD(WD),
    .RE(RE), .RA1(RA1), .RA2(RA2),
    .RD1(RD1), .RD2(RD2), .RVALID(RVALID)
  );

  // scoreboard
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   m_regs [NR];
  logic [DW-1:0]   m_rd1;
  logic [DW-1:0]   m_rd2;
  logic            m_valid;
  int              errors = 0;
  int              checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference read as seen on one edge: zero register, write-first bypass
  // or stored value.
  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a,
                                           input logic we, input logic [AW-1:0] wa,
                                           input logic [DW-1:0] wd);
    if (a == '0) return '0;
    if (we && wa != '0 && wa == a) return wd;
    return m_regs[a];
  endfunction

  // Driver: apply one edge's worth of inputs, update the model, then check
  // the outputs #1 after the edge.
  task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re,
                      input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    logic [DW-1:0] e1, e2;
    logic [2*DW-1:0] pair;
    RST = rst; WE = we; WA = wa; WD = wd; RE = re; RA1 = ra1; RA2 = ra2;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_rd1 = '0; m_rd2 = '0; m_valid = 1'b0;
      exp_q.delete();
    end else begin
      e1 = m_read(ra1, we, wa, wd);
      e2 = m_read(ra2, we, wa, wd);
      if (re) begin
        m_rd1 = e1; m_rd2 = e2;
        exp_q.push_back({e1, e2});
      end
      m_valid = re;
      if (we && wa != '0) m_regs[wa] = wd;
    end
    @(posedge CLK);
    #1;
    check("rvalid", {{(DW-1){1'b0}}, RVALID}, {{(DW-1){1'b0}}, m_valid});
    if (RVALID === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0)
      else begin
        errors++;
        $error("FAIL sb_underflow: observed=rvalid expected=no_data");
      end
      if (exp_q.size() > 0) begin
        pair = exp_q.pop_front();
        check("sb_rd1", RD1, pair[2*DW-1:DW]);
        check("sb_rd2", RD2, pair[DW-1:0]);
      end
    end
    check("hold_rd1", RD1, m_rd1);
    check("hold_rd2", RD2, m_rd2);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    step(1'b0, 1'b0, '0, '0, 1'b1, a1, a2);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_rd1 = '0; m_rd2 = '0; m_valid = 1'b0;
    @(negedge CLK);

    // reset with a write and a read on the same edge: both are dropped
    step(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd0);
    check("rst_rd1", RD1, 32'h0);
    check("rst_rd2", RD2, 32'h0);
    rd(5'd3, 5'd3);
    check("rst_reg3", RD1, 32'h0);

    // write then read, then hold
    wr(5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd0);
    check("wr_rd1", RD1, 32'hDEAD_BEEF);
    check("wr_rd2", RD2, 32'h0);
    idle();
    check("hold_after_idle", RD1, 32'hDEAD_BEEF);

    // register 0 protected
    wr(5'd0, 32'h1234_5678);
    rd(5'd0, 5'd0);
    check("r0_rd1", RD1, 32'h0);
    check("r0_rd2", RD2, 32'h0);

    // same-edge bypass on port 1; register 8 read normally on port 2
    wr(5'd7, 32'h0000_0011);
    wr(5'd8, 32'h0000_0099);
    step(1'b0, 1'b1, 5'd7, 32'h0000_0022, 1'b1, 5'd7, 5'd8);
    check("byp_rd1", RD1, 32'h0000_0022);
    check("byp_rd2", RD2, 32'h0000_0099);
    rd(5'd7, 5'd7);
    check("byp_after", RD2, 32'h0000_0022);
    // bypass on both ports, and a write to 0 while reading 0
    step(1'b0, 1'b1, 5'd9, 32'hCAFE_0001, 1'b1, 5'd9, 5'd9);
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_0000, 1'b1, 5'd0, 5'd9);

    // back-to-back reads
    wr(5'd1, 32'hA);
    wr(5'd2, 32'hB);
    wr(5'd3, 32'hC);
    rd(5'd1, 5'd3);
    check("b2b_0", RD1, 32'hA);
    rd(5'd2, 5'd2);
    check("b2b_1", RD1, 32'hB);
    rd(5'd3, 5'd1);
    check("b2b_2", RD1, 32'hC);
    idle();

    // reset mid-read
    rd(5'd5, 5'd1);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    check("midrst_rd1", RD1, 32'h0);
    rd(5'd5, 5'd1);
    check("midrst_reg5", RD1, 32'h0);

    // random traffic, including same-address reads and occasional reset
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           AW'($urandom_range(0, 15)));
    end
    idle();

    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("FAIL sb_leftover: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
